// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage and instruction memory.
// The IF stage holds the master end and also drives the busy indication.
interface if_stage_if;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic [31:0] imem_rd_data;
    logic        imem_ack;
    logic        busy;

    modport master (
        output imem_req,
        output imem_addr,
        output busy,
        input  imem_rd_data,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        input  busy,
        output imem_rd_data,
        output imem_ack
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus and drives
// the IF/ID register, with a one-slot branch delay and controller flushes.
module if_stage #(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter logic [31:0] NOP_INSN     = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [29:0] i_new_pc,
    input  logic        i_br_taken,
    input  logic [29:0] i_br_addr,
    if_stage_if.master  imem,
    output logic [29:0] o_if_pc,
    output logic [31:0] o_if_insn,
    output logic        o_if_en
);

    localparam logic [0:0] S_NORMAL  = 1'b0;
    localparam logic [0:0] S_BR_PEND = 1'b1;

    logic [29:0] r_pc;
    logic [0:0]  r_br_pend;
    logic [29:0] r_br_pend_addr;
    logic [29:0] r_if_pc;
    logic [31:0] r_if_insn;
    logic        r_if_en;

    logic        w_req;
    logic        w_br_v;

    // A branch only counts when ID holds a real instruction, never a bubble.
    assign w_req  = !reset && !i_stall && !i_flush;
    assign w_br_v = i_br_taken && r_if_en;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign imem.busy      = w_req && !imem.imem_ack;

    assign o_if_pc   = r_if_pc;
    assign o_if_insn = r_if_insn;
    assign o_if_en   = r_if_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_VECTOR;
            r_br_pend      <= S_NORMAL;
            r_br_pend_addr <= 30'h0;
            r_if_pc        <= 30'h0;
            r_if_insn      <= NOP_INSN;
            r_if_en        <= 1'b0;
        end else if (i_flush) begin
            r_pc      <= i_new_pc;
            r_br_pend <= S_NORMAL;
            r_if_insn <= NOP_INSN;
            r_if_en   <= 1'b0;
        end else if (i_stall) begin
            r_pc <= r_pc;
        end else if (imem.imem_ack) begin
            r_if_pc   <= r_pc;
            r_if_insn <= imem.imem_rd_data;
            r_if_en   <= 1'b1;
            // The just-completed fetch was the delay slot; a parked target wins.
            if (r_br_pend == S_BR_PEND) begin
                r_pc      <= r_br_pend_addr;
                r_br_pend <= S_NORMAL;
            end else if (w_br_v) begin
                r_pc <= i_br_addr;
            end else begin
                r_pc <= r_pc + 30'd1;
            end
        end else begin
            r_if_insn <= NOP_INSN;
            r_if_en   <= 1'b0;
            if (w_br_v) begin
                r_br_pend      <= S_BR_PEND;
                r_br_pend_addr <= i_br_addr;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a directed vector table, hand-written
// corner sequences and randomized traffic checked against a reference model.
module tb_if_stage;

    localparam logic [29:0] RV  = 30'h0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        rst;
        logic        stl;
        logic        fl;
        logic [29:0] npc;
        logic        bt;
        logic [29:0] ba;
        logic        ack;
        logic [31:0] data;
        logic        hasExp;
        logic [29:0] eAddr;
        logic [29:0] eIfPc;
        logic [31:0] eInsn;
        logic        eEn;
        logic        eReq;
        logic        eBusy;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [29:0] newPc;
    logic        brTaken;
    logic [29:0] brAddr;
    logic [29:0] ifPc;
    logic [31:0] ifInsn;
    logic        ifEn;

    if_stage_if imemBus ();

    if_stage #(
        .RESET_VECTOR (RV),
        .NOP_INSN     (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_stall    (stall),
        .i_flush    (flush),
        .i_new_pc   (newPc),
        .i_br_taken (brTaken),
        .i_br_addr  (brAddr),
        .imem       (imemBus),
        .o_if_pc    (ifPc),
        .o_if_insn  (ifInsn),
        .o_if_en    (ifEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the architectural PC, the IF/ID contents, and a queue
    // holding a branch target that is waiting behind an outstanding delay slot.
    logic [29:0] mPc;
    logic [29:0] mIfPc;
    logic [31:0] mInsn;
    logic        mEn;
    logic [29:0] mPendQ[$];

    task automatic modelEdge(input vec_t v);
        logic brV;
        brV = v.bt && mEn;
        if (v.rst) begin
            mPc = RV; mIfPc = 30'h0; mInsn = NOP; mEn = 1'b0;
            mPendQ.delete();
        end else if (v.fl) begin
            mPc = v.npc; mInsn = NOP; mEn = 1'b0;
            mPendQ.delete();
        end else if (v.stl) begin
            mEn = mEn;
        end else if (v.ack) begin
            mIfPc = mPc; mInsn = v.data; mEn = 1'b1;
            if (mPendQ.size() > 0) mPc = mPendQ.pop_front();
            else if (brV)          mPc = v.ba;
            else                   mPc = 30'((mPc + 1) % (64'd1 << 30));
        end else begin
            mInsn = NOP; mEn = 1'b0;
            if (brV) mPendQ.push_back(v.ba);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkModel(input vec_t v);
        logic eReq;
        eReq = !v.rst && !v.stl && !v.fl;
        checkOutput("model.imem_addr", {2'b0, imemBus.imem_addr}, {2'b0, mPc});
        checkOutput("model.if_pc", {2'b0, ifPc}, {2'b0, mIfPc});
        checkOutput("model.if_insn", ifInsn, mInsn);
        checkOutput("model.if_en", {31'b0, ifEn}, {31'b0, mEn});
        checkOutput("model.imem_req", {31'b0, imemBus.imem_req}, {31'b0, eReq});
        checkOutput("model.busy", {31'b0, imemBus.busy}, {31'b0, eReq && !v.ack});
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        reset = v.rst; stall = v.stl; flush = v.fl; newPc = v.npc;
        brTaken = v.bt; brAddr = v.ba;
        imemBus.imem_ack = v.ack; imemBus.imem_rd_data = v.data;
        #1;
        if (v.hasExp) begin
            checkOutput({tag, ".addr"}, {2'b0, imemBus.imem_addr}, {2'b0, v.eAddr});
            checkOutput({tag, ".if_pc"}, {2'b0, ifPc}, {2'b0, v.eIfPc});
            checkOutput({tag, ".if_insn"}, ifInsn, v.eInsn);
            checkOutput({tag, ".if_en"}, {31'b0, ifEn}, {31'b0, v.eEn});
            checkOutput({tag, ".req"}, {31'b0, imemBus.imem_req}, {31'b0, v.eReq});
            checkOutput({tag, ".busy"}, {31'b0, imemBus.busy}, {31'b0, v.eBusy});
        end
        checkModel(v);
        @(posedge clk);
        modelEdge(v);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic stl, input logic fl,
                                input logic [29:0] npc, input logic bt, input logic [29:0] ba,
                                input logic ack, input logic [29:0] eAddr, input logic [29:0] eIfPc,
                                input logic [31:0] eInsn, input logic eEn, input logic eReq,
                                input logic eBusy);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.npc = npc; v.bt = bt; v.ba = ba;
        v.ack = ack; v.data = 32'h1000_0000 + {2'b0, eAddr};
        v.hasExp = 1'b1; v.eAddr = eAddr; v.eIfPc = eIfPc; v.eInsn = eInsn;
        v.eEn = eEn; v.eReq = eReq; v.eBusy = eBusy;
        return v;
    endfunction

    function automatic vec_t cyc(input logic rst, input logic stl, input logic fl,
                                 input logic [29:0] npc, input logic bt, input logic [29:0] ba,
                                 input logic ack, input logic [31:0] data);
        vec_t v;
        v = '0;
        v.rst = rst; v.stl = stl; v.fl = fl; v.npc = npc; v.bt = bt; v.ba = ba;
        v.ack = ack; v.data = data;
        return v;
    endfunction

    function automatic logic [31:0] dw(input logic [29:0] a);
        return 32'h1000_0000 + {2'b0, a};
    endfunction

    vec_t table_v[15];

    initial begin
        vec_t v;
        int unsigned r;

        // Straight-line fetch, zero-wait branch, ignored branch on a bubble, stall hold.
        table_v[0]  = mk(1,0,0, 30'h0,0,30'h0,  0, 30'h0,  30'h0,  NOP,        0,0,0);
        table_v[1]  = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h0,  30'h0,  NOP,        0,1,0);
        table_v[2]  = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h1,  30'h0,  dw(30'h0),  1,1,0);
        table_v[3]  = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h2,  30'h1,  dw(30'h1),  1,1,0);
        table_v[4]  = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h3,  30'h2,  dw(30'h2),  1,1,0);
        table_v[5]  = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h4,  30'h3,  dw(30'h3),  1,1,0);
        table_v[6]  = mk(0,0,0, 30'h0,1,30'h40, 1, 30'h5,  30'h4,  dw(30'h4),  1,1,0);
        table_v[7]  = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h40, 30'h5,  dw(30'h5),  1,1,0);
        table_v[8]  = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h41, 30'h40, dw(30'h40), 1,1,0);
        table_v[9]  = mk(0,0,0, 30'h0,0,30'h0,  0, 30'h42, 30'h41, dw(30'h41), 1,1,1);
        table_v[10] = mk(0,0,0, 30'h0,1,30'h77, 1, 30'h42, 30'h41, NOP,        0,1,0);
        table_v[11] = mk(0,1,0, 30'h0,0,30'h0,  1, 30'h43, 30'h42, dw(30'h42), 1,0,0);
        table_v[12] = mk(0,1,0, 30'h0,1,30'h99, 1, 30'h43, 30'h42, dw(30'h42), 1,0,0);
        table_v[13] = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h43, 30'h42, dw(30'h42), 1,1,0);
        table_v[14] = mk(0,0,0, 30'h0,0,30'h0,  1, 30'h44, 30'h43, dw(30'h43), 1,1,0);

        reset = 1'b1; stall = 1'b0; flush = 1'b0; newPc = 30'h0;
        brTaken = 1'b0; brAddr = 30'h0;
        imemBus.imem_ack = 1'b0; imemBus.imem_rd_data = 32'h0;
        @(posedge clk);
        modelEdge(cyc(1,0,0,30'h0,0,30'h0,0,32'h0));
        #1;

        for (int i = 0; i < 15; i++)
            applyStimulus(table_v[i], $sformatf("row%0d", i));

        // Branch seen while the delay-slot fetch at pc 5 waits three cycles.
        applyStimulus(cyc(1,0,0,30'h0,0,30'h0,0,32'h0), "seqA");
        for (int i = 0; i < 5; i++)
            applyStimulus(cyc(0,0,0,30'h0,0,30'h0,1,dw(mPc)), "seqA");
        checkOutput("brwait.pc5", {2'b0, imemBus.imem_addr}, 32'h5);
        checkOutput("brwait.en_before", {31'b0, ifEn}, 32'h1);
        applyStimulus(cyc(0,0,0,30'h0,1,30'h40,0,32'h0), "seqA");
        checkOutput("brwait.busy1", {31'b0, imemBus.busy}, 32'h1);
        checkOutput("brwait.en1", {31'b0, ifEn}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(cyc(0,0,0,30'h0,0,30'h0,0,32'h0), "seqA");
            checkOutput("brwait.busy", {31'b0, imemBus.busy}, 32'h1);
            checkOutput("brwait.en", {31'b0, ifEn}, 32'h0);
            checkOutput("brwait.addr_hold", {2'b0, imemBus.imem_addr}, 32'h5);
        end
        applyStimulus(cyc(0,0,0,30'h0,0,30'h0,1,dw(30'h5)), "seqA");
        checkOutput("brwait.slot_pc", {2'b0, ifPc}, 32'h5);
        checkOutput("brwait.slot_en", {31'b0, ifEn}, 32'h1);
        checkOutput("brwait.target", {2'b0, imemBus.imem_addr}, 32'h40);
        applyStimulus(cyc(0,0,0,30'h0,0,30'h0,1,dw(30'h40)), "seqA");
        checkOutput("brwait.pend_clear", {2'b0, imemBus.imem_addr}, 32'h41);
        checkOutput("brwait.target_pc", {2'b0, ifPc}, 32'h40);

        // Flush beats a pending branch, stall, ack and a new branch together.
        applyStimulus(cyc(0,0,0,30'h0,1,30'h200,0,32'h0), "seqB");
        applyStimulus(cyc(0,1,1,30'h100,1,30'h300,1,32'hABCD_0000), "seqB");
        checkOutput("flush.req", {31'b0, imemBus.imem_req}, 32'h0);
        checkOutput("flush.addr", {2'b0, imemBus.imem_addr}, 32'h100);
        checkOutput("flush.en", {31'b0, ifEn}, 32'h0);
        checkOutput("flush.insn", ifInsn, NOP);
        applyStimulus(cyc(0,0,0,30'h0,0,30'h0,1,dw(30'h100)), "seqB");
        checkOutput("flush.pend_clear", {2'b0, imemBus.imem_addr}, 32'h101);
        checkOutput("flush.if_pc", {2'b0, ifPc}, 32'h100);

        // PC wrap at the top of the word address space.
        applyStimulus(cyc(0,0,1,30'h3FFF_FFFF,0,30'h0,0,32'h0), "seqC");
        applyStimulus(cyc(0,0,0,30'h0,0,30'h0,1,32'h5555_AAAA), "seqC");
        checkOutput("wrap.addr", {2'b0, imemBus.imem_addr}, 32'h0);
        checkOutput("wrap.if_pc", {2'b0, ifPc}, 32'h3FFF_FFFF);

        // Reset while a branch target is parked.
        applyStimulus(cyc(0,0,0,30'h0,1,30'h55,0,32'h0), "seqD");
        applyStimulus(cyc(1,0,0,30'h0,0,30'h0,1,32'h0), "seqD");
        checkOutput("rst.req", {31'b0, imemBus.imem_req}, 32'h0);
        checkOutput("rst.busy", {31'b0, imemBus.busy}, 32'h0);
        checkOutput("rst.addr", {2'b0, imemBus.imem_addr}, {2'b0, RV});
        checkOutput("rst.en", {31'b0, ifEn}, 32'h0);
        applyStimulus(cyc(0,0,0,30'h0,0,30'h0,1,dw(RV)), "seqD");
        checkOutput("rst.pend_clear", {2'b0, imemBus.imem_addr}, {2'b0, RV + 30'd1});

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            v = '0;
            r = $urandom_range(0, 999);
            v.rst = (r < 8);
            v.fl  = ($urandom_range(0, 99) < 5);
            v.stl = ($urandom_range(0, 99) < 12);
            v.ack = ($urandom_range(0, 99) < 65);
            v.bt  = ($urandom_range(0, 99) < 30);
            v.ba  = 30'($urandom);
            v.npc = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
            v.data = $urandom;
            applyStimulus(v, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage CPU. It holds the program counter, issues word fetches to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register (`if_pc`, `if_insn`, `if_en`) consumed by the ID-stage decoder. It applies branch redirects from the decoder with one architectural delay slot, and it applies flush redirects from the pipeline controller.

## Interface
- `RESET_VECTOR`, default 30'h0: word address loaded into the PC on reset.
- `NOP_INSN`, default 32'h0: value driven on `if_insn` while the stage holds a bubble.
- `clk` input, 1 bit: the single clock. Everything is clocked on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `stall` input, 1 bit: pipeline stall from the controller. While high, the stage holds all of its state.
- `flush` input, 1 bit: pipeline flush from the controller. While high, the stage redirects to `new_pc`.
- `new_pc` input, 30 bits: flush target word address.
- `br_taken` input, 1 bit: branch-taken signal from the decoder.
- `br_addr` input, 30 bits: branch target word address from the decoder.
- `imem_req` output, 1 bit: fetch request. Combinational: `!reset && !stall && !flush`.
- `imem_addr` output, 30 bits: fetch word address. Equals the PC register.
- `imem_rd_data` input, 32 bits: instruction word. Valid only in a cycle where `imem_ack` is high.
- `imem_ack` input, 1 bit: fetch complete in this cycle. Only meaningful while `imem_req` is high.
- `busy` output, 1 bit: fetch outstanding. Combinational: `imem_req && !imem_ack`.
- `if_pc` output, 30 bits: IF/ID register, PC of `if_insn`.
- `if_insn` output, 32 bits: IF/ID register, the instruction word.
- `if_en` output, 1 bit: IF/ID register, high when the ID stage holds a valid instruction.

## Operation
- Internal state:
  - `pc` (30 bits).
  - `br_pend` (1 bit) and `br_pend_addr` (30 bits).
  - `br_pend` forms a 2-state FSM: NORMAL (0) and BR_PEND (1).
- Valid branch: `br_v = br_taken && if_en`. A `br_taken` with `if_en == 0` is ignored.
- Per-edge priority is reset > flush > stall > fetch-complete > fetch-wait.
- **reset**:
  - `pc` ← `RESET_VECTOR`, `if_pc` ← 0, `if_insn` ← `NOP_INSN`, `if_en` ← 0, `br_pend` ← 0, `br_pend_addr` ← 0.
  - Combinational outputs during reset: `imem_req` = 0, `busy` = 0.
- **flush**:
  - `pc` ← `new_pc`, `if_en` ← 0, `if_insn` ← `NOP_INSN`, `if_pc` holds, `br_pend` ← 0.
  - Any `imem_ack` or `br_taken` in the flush cycle is discarded.
- **stall** (`flush` low):
  - All registers hold.
  - `imem_req` is 0, so no fetch completes and `imem_ack` is ignored.
  - A branch presented by the decoder is not captured; the decoder re-presents it after the stall.
- **Fetch complete** (`imem_req && imem_ack`):
  - `if_pc` ← `pc`, `if_insn` ← `imem_rd_data`, `if_en` ← 1.
  - Next `pc`:
    - if `br_pend`: `br_pend_addr`, and `br_pend` ← 0;
    - else if `br_v`: `br_addr`;
    - else: `pc + 1`, wrapping from 30'h3FFFFFFF to 0 (modulo 2^30).
- **Fetch wait** (`imem_req && !imem_ack`):
  - `pc` holds, `if_en` ← 0 (bubble), `if_insn` ← `NOP_INSN`, `if_pc` holds.
  - If `br_v`: `br_pend` ← 1 and `br_pend_addr` ← `br_addr`. The delay-slot fetch at `pc` stays outstanding.
- Delay slot: the instruction fetched in the cycle a valid branch is seen always enters ID with `if_en` = 1. The target follows it.
- NORMAL → BR_PEND occurs on `br_v` during fetch wait. BR_PEND → NORMAL occurs on fetch complete or on flush.
- In BR_PEND, `if_en` is 0, so no second branch can arrive.

## Timing
- Zero-wait memory (ack in the request cycle): one instruction per cycle. The instruction at `pc` appears on `if_insn` with `if_en` = 1 one edge after the ack.
- An N-cycle ack delay inserts N bubbles (`if_en` = 0) and holds `busy` high for N cycles.
- Branch redirect:
  - With ack in the `br_v` cycle, `imem_addr` = `br_addr` in the next cycle.
  - Otherwise, `imem_addr` = `br_addr` in the cycle after the delay-slot ack.
- Flush: `imem_addr` = `new_pc` and `if_en` = 0 in the cycle after the flush. `imem_req` is 0 during the flush cycle.
- Reset released: in the first cycle, `imem_addr` = `RESET_VECTOR` and `imem_req` = 1.

## Test plan
- **Reset, then straight-line fetch.** Reset, then ack every cycle with data = 0x1000_0000 + addr. Required:
  - `imem_addr` sequence 0, 1, 2, …
  - `if_insn` = 0x1000_0000, 0x1000_0001, … with `if_en` = 1 from cycle 2, one cycle behind `imem_addr`.
  - `if_pc` tracks with the same one-cycle lag.
- **Taken branch, zero wait.** `if_en` = 1, `br_taken` = 1, `br_addr` = 0x40, `pc` = 5. Required:
  - Next `imem_addr` = 0x40.
  - `if_pc` = 5 (delay slot) with `if_en` = 1, followed by `if_pc` = 0x40.
- **Branch during wait.** Same branch as above, but the ack is delayed 3 cycles. Required:
  - `busy` = 1 for 3 cycles and `if_en` = 0 for those cycles.
  - On the ack, `if_pc` = 5, then `imem_addr` = 0x40.
  - `br_pend` returns to 0.
- **Ignored branch and stall hold.**
  - `br_taken` = 1 with `if_en` = 0: required sequential PC, no redirect.
  - `stall` for 2 cycles: required all outputs frozen, `imem_req` = 0, and an ack during the stall ignored.
- **Flush priority.** In one cycle, flush with `new_pc` = 0x100 together with `br_taken`, `stall`, `imem_ack`, and `br_pend` = 1. Required:
  - Next `imem_addr` = 0x100, `if_en` = 0, `br_pend` = 0.
- **Wrap and mid-operation reset.**
  - `pc` = 0x3FFFFFFF with ack: required next `imem_addr` = 0.
  - Reset asserted while in BR_PEND: required return to `RESET_VECTOR` with `if_en` = 0.
